// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer datapath: address widths, sequencer states and
// default layer dimensions.
package mlp_pkg;

  localparam int unsigned NEURON_ADDR_W = 12;
  localparam int unsigned WEIGHT_ADDR_W = 16;

  localparam int unsigned DEF_NUM_INPUTS   = 784;
  localparam int unsigned DEF_NUM_OUTPUTS  = 64;
  localparam int unsigned DEF_READ_LATENCY = 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/control_unit.sv
// Layer sequencer: walks every (output, input) neuron pair, streaming memory addresses,
// clearing the MAC before each output neuron and strobing the result write.
module control_unit
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int unsigned NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [NEURON_ADDR_W-1:0] input_neuron_addr,
  output logic [NEURON_ADDR_W-1:0] output_neuron_addr,
  output logic [WEIGHT_ADDR_W-1:0] input_weight_addr,
  output logic                     reset_mult_acc,
  output logic                     write_neuron,
  output logic                     done
);

  localparam logic [NEURON_ADDR_W-1:0] LastIn    = NEURON_ADDR_W'(NUM_INPUTS - 1);
  localparam logic [NEURON_ADDR_W-1:0] LastOut   = NEURON_ADDR_W'(NUM_OUTPUTS - 1);
  localparam logic [1:0]               LastDrain = 2'(READ_LATENCY - 1);

  state_e     state;
  logic [1:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= StIdle;
      input_neuron_addr  <= '0;
      output_neuron_addr <= '0;
      input_weight_addr  <= '0;
      drain_cnt          <= '0;
      reset_mult_acc     <= 1'b1;
      write_neuron       <= 1'b0;
      done               <= 1'b0;
    end else begin
      write_neuron <= 1'b0;
      unique case (state)
        StIdle: begin
          reset_mult_acc <= 1'b1;
          if (start) begin
            state              <= StClear;
            input_neuron_addr  <= '0;
            output_neuron_addr <= '0;
            input_weight_addr  <= '0;
          end
        end
        StClear: begin
          state          <= StAccum;
          // First ACCUM cycle sees stale bus data whenever the memory has latency.
          reset_mult_acc <= (READ_LATENCY != 0);
        end
        StAccum: begin
          if (input_neuron_addr == LastIn) begin
            reset_mult_acc <= 1'b0;
            if (READ_LATENCY != 0) begin
              state     <= StDrain;
              drain_cnt <= '0;
            end else begin
              state        <= StWrite;
              write_neuron <= 1'b1;
            end
          end else begin
            input_neuron_addr <= input_neuron_addr + 1'b1;
            input_weight_addr <= input_weight_addr + 1'b1;
            reset_mult_acc    <= ((32'(input_neuron_addr) + 32'd1) < READ_LATENCY);
          end
        end
        StDrain: begin
          if (drain_cnt == LastDrain) begin
            state        <= StWrite;
            write_neuron <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        StWrite: begin
          reset_mult_acc <= 1'b1;
          if (output_neuron_addr == LastOut) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            // Weight counter runs on, landing on (o+1)*NUM_INPUTS.
            state              <= StClear;
            output_neuron_addr <= output_neuron_addr + 1'b1;
            input_neuron_addr  <= '0;
            input_weight_addr  <= input_weight_addr + 1'b1;
          end
        end
        StDone: begin
          reset_mult_acc <= 1'b1;
          if (!start) begin
            state <= StIdle;
            done  <= 1'b0;
          end
        end
        default: begin
          state          <= StIdle;
          reset_mult_acc <= 1'b1;
          done           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: four parameterisations run side by side against an
// arithmetic model indexed by the number of edges since start was sampled.
module tb_control_unit;
  import mlp_pkg::*;

  localparam int NINST = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic [11:0] ia [NINST];
  logic [11:0] oa [NINST];
  logic [15:0] wa [NINST];
  logic        rma[NINST];
  logic        wr [NINST];
  logic        dn [NINST];

  always #5 clk = ~clk;

  control_unit #(.NUM_INPUTS(4), .NUM_OUTPUTS(3), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start),
    .input_neuron_addr(ia[0]), .output_neuron_addr(oa[0]), .input_weight_addr(wa[0]),
    .reset_mult_acc(rma[0]), .write_neuron(wr[0]), .done(dn[0])
  );
  control_unit #(.NUM_INPUTS(4), .NUM_OUTPUTS(3), .READ_LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .input_neuron_addr(ia[1]), .output_neuron_addr(oa[1]), .input_weight_addr(wa[1]),
    .reset_mult_acc(rma[1]), .write_neuron(wr[1]), .done(dn[1])
  );
  control_unit #(.NUM_INPUTS(784), .NUM_OUTPUTS(64), .READ_LATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start),
    .input_neuron_addr(ia[2]), .output_neuron_addr(oa[2]), .input_weight_addr(wa[2]),
    .reset_mult_acc(rma[2]), .write_neuron(wr[2]), .done(dn[2])
  );
  control_unit #(.NUM_INPUTS(3), .NUM_OUTPUTS(2), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start),
    .input_neuron_addr(ia[3]), .output_neuron_addr(oa[3]), .input_weight_addr(wa[3]),
    .reset_mult_acc(rma[3]), .write_neuron(wr[3]), .done(dn[3])
  );

  typedef struct {
    int i;
    int o;
    int w;
    int rma;
    int wr;
    int done;
  } exp_t;

  typedef struct {
    int   inst;
    int   k;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int k    [NINST];
  bit known[NINST];

  function automatic void dims(input int j, output int ni, output int no, output int rl);
    case (j)
      0:       begin ni = 4;   no = 3;  rl = 1; end
      1:       begin ni = 4;   no = 3;  rl = 0; end
      2:       begin ni = 784; no = 64; rl = 1; end
      default: begin ni = 3;   no = 2;  rl = 3; end
    endcase
  endfunction

  // Expected outputs kk edges after start was sampled (kk==0: idle after reset).
  function automatic exp_t model(input int j, input int kk);
    int ni, no, rl, p, n, r;
    exp_t e;
    dims(j, ni, no, rl);
    p = ni + rl + 2;
    e = '{i: 0, o: 0, w: 0, rma: 1, wr: 0, done: 0};
    if (kk > no * p) begin
      e = '{i: ni - 1, o: no - 1, w: no * ni - 1, rma: 1, wr: 0, done: 1};
    end else if (kk > 0) begin
      n = (kk - 1) / p;
      r = (kk - 1) % p;
      e.o = n;
      if (r == 0) begin
        e.w = n * ni;
      end else if (r <= ni) begin
        e.i   = r - 1;
        e.w   = n * ni + r - 1;
        e.rma = (r - 1 < rl) ? 1 : 0;
      end else begin
        e.i   = ni - 1;
        e.w   = n * ni + ni - 1;
        e.rma = 0;
        e.wr  = (r == p - 1) ? 1 : 0;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int j, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s inst%0d k=%0d: got %0d expected %0d", name, j, k[j], act, exp_v);
    end
  endtask

  task automatic check_vs(input string tag, input int j, input exp_t e, input bit addrs);
    chk({tag, "done"}, j, int'(dn[j]), e.done);
    chk({tag, "write_neuron"}, j, int'(wr[j]), e.wr);
    chk({tag, "reset_mult_acc"}, j, int'(rma[j]), e.rma);
    if (addrs) begin
      chk({tag, "input_neuron_addr"}, j, int'(ia[j]), e.i);
      chk({tag, "output_neuron_addr"}, j, int'(oa[j]), e.o);
      chk({tag, "input_weight_addr"}, j, int'(wa[j]), e.w);
    end
  endtask

  task automatic step();
    int ni, no, rl;
    @(posedge clk);
    for (int j = 0; j < NINST; j++) begin
      dims(j, ni, no, rl);
      if (reset) begin
        k[j] = 0;
        known[j] = 1'b1;
      end else if (k[j] == 0) begin
        if (start) k[j] = 1;
      end else if (k[j] <= no * (ni + rl + 2)) begin
        k[j]++;
      end else if (!start) begin
        k[j] = 0;
        known[j] = 1'b0;  // idle address contents after a finished run are unspecified
      end
    end
    #1;
    for (int j = 0; j < NINST; j++)
      check_vs("model ", j, model(j, k[j]), (k[j] != 0) || known[j]);
  endtask

  vec_t tab[$];
  int   edge_n;
  bit   seen;

  initial begin
    for (int j = 0; j < NINST; j++) begin
      k[j] = 0;
      known[j] = 1'b0;
    end

    // 4/3/1 and 4/3/0 address traces at selected cycles after start.
    tab.push_back('{0, 1,  '{0, 0, 0,  1, 0, 0}});
    tab.push_back('{0, 2,  '{0, 0, 0,  1, 0, 0}});
    tab.push_back('{0, 3,  '{1, 0, 1,  0, 0, 0}});
    tab.push_back('{0, 5,  '{3, 0, 3,  0, 0, 0}});
    tab.push_back('{0, 6,  '{3, 0, 3,  0, 0, 0}});
    tab.push_back('{0, 7,  '{3, 0, 3,  0, 1, 0}});
    tab.push_back('{0, 8,  '{0, 1, 4,  1, 0, 0}});
    tab.push_back('{0, 9,  '{0, 1, 4,  1, 0, 0}});
    tab.push_back('{0, 12, '{3, 1, 7,  0, 0, 0}});
    tab.push_back('{0, 14, '{3, 1, 7,  0, 1, 0}});
    tab.push_back('{0, 16, '{0, 2, 8,  1, 0, 0}});
    tab.push_back('{0, 21, '{3, 2, 11, 0, 1, 0}});
    tab.push_back('{0, 22, '{3, 2, 11, 1, 0, 1}});
    tab.push_back('{1, 1,  '{0, 0, 0,  1, 0, 0}});
    tab.push_back('{1, 2,  '{0, 0, 0,  0, 0, 0}});
    tab.push_back('{1, 5,  '{3, 0, 3,  0, 0, 0}});
    tab.push_back('{1, 6,  '{3, 0, 3,  0, 1, 0}});
    tab.push_back('{1, 7,  '{0, 1, 4,  1, 0, 0}});
    tab.push_back('{1, 18, '{3, 2, 11, 0, 1, 0}});
    tab.push_back('{1, 19, '{3, 2, 11, 1, 0, 1}});

    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_vs("reset ", 0, '{0, 0, 0, 1, 0, 0}, 1'b1);

    start = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      foreach (tab[t])
        if (tab[t].k == e) check_vs("table ", tab[t].inst, tab[t].e, 1'b1);
    end

    // Held start after done: no rerun, no writes.
    for (int c = 0; c < 8; c++) begin
      step();
      chk("hold_done", 0, int'(dn[0]), 1);
      chk("hold_no_write", 0, int'(wr[0]), 0);
    end
    start = 1'b0;
    step();
    chk("idle_done", 0, int'(dn[0]), 0);

    // Rerun: the model checks the identical trace every cycle.
    start = 1'b1;
    for (int e = 1; e <= 22; e++) step();
    chk("rerun_done", 0, int'(dn[0]), 1);

    // Reset during neuron 1 ACCUM, then restart from o=0.
    start = 1'b0;
    step();
    start = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    chk("pre_reset_o", 0, int'(oa[0]), 1);
    reset = 1'b1;
    step();
    check_vs("midreset ", 0, '{0, 0, 0, 1, 0, 0}, 1'b1);
    reset = 1'b0;
    step();
    step();
    check_vs("restart ", 0, '{0, 0, 0, 1, 0, 0}, 1'b1);

    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) != 0);
      step();
    end

    // Default-size layer: done timing and final weight address.
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
    start = 1'b1;
    edge_n = 0;
    seen = 1'b0;
    while (!seen && edge_n < 50500) begin
      step();
      edge_n++;
      if (dn[2]) seen = 1'b1;
    end
    chk("default_done_cycle", 2, seen ? edge_n : -1, 50369);
    chk("default_final_waddr", 2, int'(wa[2]), 50175);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
